// File: rtl/pcpu_bus_pkg.sv
// Shared bus encodings for the fetch unit and the memory arbiter:
// arbiter FSM states and the address-source select values.
package pcpu_bus_pkg;

    localparam int unsigned ST_W  = 3;
    localparam int unsigned SEL_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_I_LO = 3'd1;
    localparam logic [ST_W-1:0] ST_I_HI = 3'd2;
    localparam logic [ST_W-1:0] ST_D_RD = 3'd3;
    localparam logic [ST_W-1:0] ST_D_WR = 3'd4;

    localparam logic [SEL_W-1:0] SEL_NONE = 2'd0;
    localparam logic [SEL_W-1:0] SEL_PC   = 2'd1;
    localparam logic [SEL_W-1:0] SEL_PRED = 2'd2;

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles without a memory acknowledge since the last clear;
// expired flags the cycle in which the LIMIT-th such cycle completes.
module bus_watchdog #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = tick & (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a 16-bit word memory between two-beat instruction fetches and
// single-beat data accesses. Optional ack timeout: define BUS_TIMEOUT_EN.
module mem_arbiter
    import pcpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic [1:0]  addr_bus_mux_ctl,
    input  logic [15:0] pc_in,
    input  logic [15:0] predi_pc,
    input  logic        data_rd,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic [31:0] ram_out,
    output logic        ram_data_ready,
    output logic        ram_busy,
    output logic [15:0] data_rdata,
    output logic        data_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        bus_err
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    logic [ST_W-1:0] state_q, state_d;
    logic [AW-1:0]   iaddr_q, iaddr_d;
    logic [2*DW-1:0] ram_out_q, ram_out_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            iready_q, iready_d;
    logic            dready_q, dready_d;
    logic            err_q, err_d;
    logic            expired_c;

`ifdef BUS_TIMEOUT_EN
    logic wd_clear_c;

    // Restart the count in IDLE and on every accepted beat (state entry).
    assign wd_clear_c = (state_q == ST_IDLE) | mem_ack;

    bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_c),
        .tick    (!mem_ack),
        .expired (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    assign ram_busy       = (state_q != ST_IDLE) | data_rd | data_wr;
    assign ram_out        = ram_out_q;
    assign ram_data_ready = iready_q;
    assign data_rdata     = rdata_q;
    assign data_ready     = dready_q;
    assign bus_err        = err_q;

    always_comb begin
        state_d   = state_q;
        iaddr_d   = iaddr_q;
        ram_out_d = ram_out_q;
        rdata_d   = rdata_q;
        iready_d  = 1'b0;
        dready_d  = 1'b0;
        err_d     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                // The data requester still holds its level during the
                // data_ready cycle, so that cycle must not start a transfer.
                if (!dready_q) begin
                    if (data_wr) begin
                        state_d = ST_D_WR;
                    end else if (data_rd) begin
                        state_d = ST_D_RD;
                    end else if (ram_read) begin
                        if (addr_bus_mux_ctl == SEL_PC) begin
                            iaddr_d = pc_in;
                            state_d = ST_I_LO;
                        end else if (addr_bus_mux_ctl == SEL_PRED) begin
                            iaddr_d = predi_pc;
                            state_d = ST_I_LO;
                        end
                    end
                end
            end
            ST_I_LO: begin
                mem_req  = 1'b1;
                mem_addr = {iaddr_q, 1'b0};
                if (mem_ack) begin
                    ram_out_d[DW-1:0] = mem_rdata;
                    state_d           = ST_I_HI;
                end else if (expired_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_I_HI: begin
                mem_req  = 1'b1;
                mem_addr = {iaddr_q, 1'b1};
                if (mem_ack) begin
                    ram_out_d[2*DW-1:DW] = mem_rdata;
                    iready_d             = 1'b1;
                    state_d              = ST_IDLE;
                end else if (expired_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_D_RD, ST_D_WR: begin
                mem_req   = 1'b1;
                mem_we    = (state_q == ST_D_WR);
                mem_addr  = {1'b0, data_addr};
                mem_wdata = data_wdata;
                if (mem_ack) begin
                    if (state_q == ST_D_RD) begin
                        rdata_d = mem_rdata;
                    end
                    dready_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expired_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            iaddr_q   <= '0;
            ram_out_q <= '0;
            rdata_q   <= '0;
            iready_q  <= 1'b0;
            dready_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            iaddr_q   <= iaddr_d;
            ram_out_q <= ram_out_d;
            rdata_q   <= rdata_d;
            iready_q  <= iready_d;
            dready_q  <= dready_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a shadow memory predicts every fetch,
// read and write completion; a monitor pops predictions on each pulse.
module tb_mem_arbiter;

    localparam int unsigned TO = 64;
    localparam int unsigned MEM_WORDS = 131072;

    logic        clk;
    logic        rst;
    logic        ram_read;
    logic [1:0]  addr_bus_mux_ctl;
    logic [15:0] pc_in, predi_pc;
    logic        data_rd, data_wr;
    logic [15:0] data_addr, data_wdata;
    logic [31:0] ram_out;
    logic        ram_data_ready, ram_busy;
    logic [15:0] data_rdata;
    logic        data_ready;
    logic        mem_req, mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        bus_err;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .ram_read         (ram_read),
        .addr_bus_mux_ctl (addr_bus_mux_ctl),
        .pc_in            (pc_in),
        .predi_pc         (predi_pc),
        .data_rd          (data_rd),
        .data_wr          (data_wr),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .ram_out          (ram_out),
        .ram_data_ready   (ram_data_ready),
        .ram_busy         (ram_busy),
        .data_rdata       (data_rdata),
        .data_ready       (data_ready),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .bus_err          (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 fetch, 1 data read, 2 data write, 3 bus error
    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_arr [0:MEM_WORDS-1];
    logic [15:0] ref_mem [0:MEM_WORDS-1];
    logic [15:0] model_rdata;
    int          errors = 0;
    int          checks = 0;
    int          gap = 0;
    bit          fast = 1'b1;
    bit          hold_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: acks after 0..2 idle cycles (0 in fast mode).
    always @(negedge clk) begin
        if (!mem_req || hold_ack) begin
            mem_ack = 1'b0;
            gap = fast ? 0 : int'($urandom_range(0, 2));
        end else if (gap > 0) begin
            mem_ack = 1'b0;
            gap--;
        end else begin
            mem_ack   = 1'b1;
            mem_rdata = mem_arr[mem_addr];
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
            gap = fast ? 0 : int'($urandom_range(0, 2));
        end
    end

    task automatic score(input int kind, input logic [31:0] val);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d value 0x%0h, expected none at %0t", kind, val, $time);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(kind), 32'((e.kind == 2) ? 1 : e.kind));
            chk("event_value", val, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_data_ready) score(0, ram_out);
            if (data_ready)     score(1, {16'h0, data_rdata});
            if (bus_err)        score(3, 32'h0);
        end
    end

    function automatic logic [31:0] fetch_word(input logic [15:0] a);
        return {ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]};
    endfunction

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (sb.size() == 0 && !ram_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic fetch_op(input logic [1:0] sel, input logic [15:0] pc,
                            input logic [15:0] pred, input bit stray);
        bit acc;
        acc = (sel == 2'd1) || (sel == 2'd2);
        ram_read = 1'b1;
        addr_bus_mux_ctl = sel;
        pc_in = pc;
        predi_pc = pred;
        if (acc) sb.push_back('{0, fetch_word((sel == 2'd1) ? pc : pred)});
        tick();
        ram_read = stray && acc;
        if (!acc) begin
            #1;
            chk("drop_busy", 32'(ram_busy), 32'd0);
            chk("drop_req", 32'(mem_req), 32'd0);
        end
        tick();
        ram_read = 1'b0;
    endtask

    task automatic data_op(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                           input bit stray, input logic [1:0] ssel,
                           input logic [15:0] spc, input bit late);
        bit seen = 1'b0;
        data_wr = wr;
        data_rd = !wr;
        data_addr = a;
        data_wdata = wd;
        if (stray) begin
            ram_read = 1'b1;
            addr_bus_mux_ctl = ssel;
            pc_in = spc;
            predi_pc = spc;
        end
        if (wr) begin
            sb.push_back('{2, {16'h0, model_rdata}});
            ref_mem[{1'b0, a}] = wd;
        end else begin
            model_rdata = ref_mem[{1'b0, a}];
            sb.push_back('{1, {16'h0, model_rdata}});
        end
        #1;
        chk("busy_on_data", 32'(ram_busy), 32'd1);
        tick();
        ram_read = 1'b0;
        chk("data_req", 32'(mem_req), 32'd1);
        chk("data_we", 32'(mem_we), 32'(wr));
        chk("data_addr", 32'(mem_addr), {15'h0, 1'b0, a});
        chk("data_wdata", 32'(mem_wdata), {16'h0, wd});
        for (int n = 0; n < 200; n++) begin
            if (data_ready) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("data_done_timeout", 32'(seen), 32'd1);
        if (late) tick();
        data_rd = 1'b0;
        data_wr = 1'b0;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem_arr[i] = 16'(i);
            ref_mem[i] = 16'(i);
        end
        model_rdata = 16'h0;
        rst = 1'b1;
        ram_read = 1'b0;
        addr_bus_mux_ctl = 2'd0;
        pc_in = 16'h0;
        predi_pc = 16'h0;
        data_rd = 1'b0;
        data_wr = 1'b0;
        data_addr = 16'h0;
        data_wdata = 16'h0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ram_out", ram_out, 32'h0);
        chk("rst_data_rdata", 32'(data_rdata), 32'h0);
        chk("rst_ram_ready", 32'(ram_data_ready), 32'd0);
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_busy", 32'(ram_busy), 32'd0);
        rst = 1'b0;
        tick();

        // Two-beat fetch from pc_in with a memory returning its own address.
        fast = 1'b1;
        ram_read = 1'b1; addr_bus_mux_ctl = 2'd1; pc_in = 16'h0010;
        sb.push_back('{0, 32'h0021_0020});
        tick();
        ram_read = 1'b0;
        chk("f_req_lo", 32'(mem_req), 32'd1);
        chk("f_addr_lo", 32'(mem_addr), 32'h20);
        tick();
        chk("f_addr_hi", 32'(mem_addr), 32'h21);
        chk("f_ready_early", 32'(ram_data_ready), 32'd0);
        tick();
        chk("f_ready_lat2", 32'(ram_data_ready), 32'd1);
        chk("f_ram_out", ram_out, 32'h0021_0020);
        tick();
        chk("f_ready_pulse", 32'(ram_data_ready), 32'd0);
        chk("f_ram_out_hold", ram_out, 32'h0021_0020);
        wait_idle();

        // Unselected address source drops the fetch.
        fetch_op(2'd0, 16'h0040, 16'h0041, 1'b0);
        chk("sel0_no_req", 32'(mem_req), 32'd0);
        wait_idle();

        // Data read beats a same-cycle fetch; the fetch is lost.
        data_op(1'b0, 16'h0100, 16'h0, 1'b1, 2'd2, 16'h0011, 1'b1);
        wait_idle();
        chk("rd_rdata", 32'(data_rdata), 32'h0100);

        // Write leaves data_rdata untouched.
        data_op(1'b1, 16'h0200, 16'hBEEF, 1'b0, 2'd0, 16'h0, 1'b1);
        wait_idle();
        chk("wr_rdata_kept", 32'(data_rdata), 32'h0100);
        chk("wr_mem", 32'(mem_arr[17'h200]), 32'hBEEF);

        // Reset during the high beat aborts the fetch.
        ram_read = 1'b1; addr_bus_mux_ctl = 2'd1; pc_in = 16'h0030;
        tick();
        ram_read = 1'b0;
        tick();
        hold_ack = 1'b1;
        chk("abort_addr_hi", 32'(mem_addr), 32'h61);
        rst = 1'b1;
        tick();
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_ram_out", ram_out, 32'h0);
        chk("abort_no_ready", 32'(ram_data_ready), 32'd0);
        chk("abort_rdata", 32'(data_rdata), 32'h0);
        rst = 1'b0;
        hold_ack = 1'b0;
        model_rdata = 16'h0;
        tick();
        fetch_op(2'd1, 16'h0030, 16'h0, 1'b0);
        wait_idle();

        // Memory that never acks.
        hold_ack = 1'b1;
        ram_read = 1'b1; addr_bus_mux_ctl = 2'd1; pc_in = 16'h0005;
        tick();
        ram_read = 1'b0;
`ifdef BUS_TIMEOUT_EN
        begin
            int n = 0;
            sb.push_back('{3, 32'h0});
            while (!bus_err && n < int'(TO) + 20) begin
                tick();
                n++;
            end
            chk("to_cycles", 32'(n), 32'(TO));
            chk("to_busy", 32'(ram_busy), 32'd0);
            chk("to_req", 32'(mem_req), 32'd0);
            chk("to_no_ready", 32'(ram_data_ready), 32'd0);
            hold_ack = 1'b0;
        end
`else
        begin
            bit err_seen = 1'b0;
            repeat (TO + 36) begin
                tick();
                if (bus_err) err_seen = 1'b1;
            end
            chk("hang_req", 32'(mem_req), 32'd1);
            chk("hang_busy", 32'(ram_busy), 32'd1);
            chk("hang_no_err", 32'(err_seen), 32'd0);
            sb.push_back('{0, fetch_word(16'h0005)});
            hold_ack = 1'b0;
        end
`endif
        wait_idle();

        // Randomized mix against the shadow memory.
        for (int it = 0; it < 150; it++) begin
            int op;
            fast = ($urandom_range(0, 1) == 1);
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                fetch_op(2'($urandom_range(0, 3)), 16'($urandom_range(0, 31)),
                         16'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1));
            end else begin
                data_op(op == 2, 16'($urandom_range(0, 63)), 16'($urandom),
                        ($urandom_range(0, 1) == 1), 2'($urandom_range(1, 2)),
                        16'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1));
            end
            wait_idle();
        end

        repeat (4) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, mem_ack wait limit in cycles (used only under BUS_TIMEOUT_EN; legal range 2..255).
REQ-002 SHALL have ports: clk in 1, single clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst in 1, synchronous, active-high reset.
REQ-004 SHALL have ports: ram_read in 1, instruction fetch request pulse from fetch.
REQ-005 SHALL have ports: addr_bus_mux_ctl in 2, address select: 1=pc_in, 2=predi_pc, 0/3=no source.
REQ-006 SHALL have ports: pc_in in 16, current PC; predi_pc in 16, predicted PC.
REQ-007 SHALL have ports: data_rd in 1, data_wr in 1, data_addr in 16, data_wdata in 16, level requests from execute, held until data_ready.
REQ-008 SHALL have ports: ram_out out 32, fetched instruction; ram_data_ready out 1; ram_busy out 1.
REQ-009 SHALL have ports: data_rdata out 16, data_ready out 1, one-cycle completion pulse for the data port.
REQ-010 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 17, mem_wdata out 16, mem_ack in 1, mem_rdata in 16, 16-bit word backing memory.
REQ-011 SHALL have ports: bus_err out 1, one-cycle timeout pulse (tied 0 without BUS_TIMEOUT_EN).

Function
REQ-012 SHALL implement FSM states IDLE, I_LO, I_HI, D_RD, D_WR.
REQ-013 In IDLE, data_rd or data_wr SHALL win over ram_read; data_wr wins over data_rd when both are high.
REQ-014 In IDLE with no data request, ram_read=1 and addr_bus_mux_ctl in {1,2} SHALL latch the selected address and enter I_LO; with ram_read=1 and select 0/3, the request SHALL be dropped.
REQ-015 ram_read SHALL never be queued; a request arriving while not IDLE, or losing to data, is dropped.
REQ-016 ram_busy SHALL be combinational: (state != IDLE) | data_rd | data_wr.
REQ-017 I_LO SHALL drive mem_req=1, mem_we=0, mem_addr={addr,1'b0}; on mem_ack it captures mem_rdata into ram_out[15:0] and enters I_HI with mem_req held high.
REQ-018 I_HI SHALL drive mem_addr={addr,1'b1}; on mem_ack it captures ram_out[31:16], pulses ram_data_ready for one cycle, and returns to IDLE.
REQ-019 ram_out SHALL hold its value between fetches; ram_data_ready SHALL never assert for data transfers.
REQ-020 D_RD/D_WR SHALL drive mem_addr={1'b0,data_addr}, mem_we=1 only in D_WR, mem_wdata=data_wdata; on mem_ack data_rdata loads (D_RD only), data_ready pulses one cycle, and the FSM returns to IDLE.
REQ-021 Latency with a memory acking one cycle after mem_req: instruction 2 cycles from acceptance to ram_data_ready; data 1 cycle.
REQ-022 mem_ack SHALL be ignored in IDLE; mem_req SHALL be low in IDLE.
REQ-023 After data_ready, the requester dropping its request in the next cycle SHALL NOT start a second transfer (IDLE re-samples only on the cycle after the pulse).

Reset
REQ-024 rst SHALL force IDLE and zero all outputs, ram_out and data_rdata included, on the next edge, aborting any transfer mid-beat (mem_req low next cycle; no completion pulse).

Configuration
REQ-025 With BUS_TIMEOUT_EN defined, a counter SHALL clear on entry to each non-IDLE state and count cycles without mem_ack; on reaching TIMEOUT_CYCLES it pulses bus_err, drops mem_req, returns to IDLE, and emits neither ready pulse.
REQ-026 Without BUS_TIMEOUT_EN, the FSM SHALL wait for mem_ack indefinitely, bus_err SHALL be constant 0, and no counter logic SHALL exist.

Structure
REQ-027 FSM state encodings and the addr_bus_mux_ctl encodings (NONE=0, PC=1, PRED=2) SHALL live in shared package pcpu_bus_pkg, also used by fetch.
REQ-028 The timeout counter SHALL be sub-module bus_watchdog (clk, rst, clear, tick, expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-029 IDLE, ram_read=1, sel=1, pc_in=0x0010, memory acking 1 cycle after req with rdata=addr -> mem_addr 0x00020 then 0x00021; ram_out=0x00210020; ram_data_ready one pulse 2 cycles after acceptance.
REQ-030 Same cycle ram_read=1 (sel=2, predi_pc=0x0011) and data_rd=1 at 0x0100 -> D_RD first; ram_busy=1; instruction dropped; data_ready pulse with data_rdata=0x0100; no ram_data_ready.
REQ-031 data_wr=1, addr 0x0200, wdata 0xBEEF -> one mem_req with mem_we=1, mem_addr=0x00200, mem_wdata=0xBEEF; data_ready pulse; data_rdata unchanged.
REQ-032 rst asserted in I_HI -> next cycle state IDLE, mem_req=0, ram_out=0, no ram_data_ready; following fetch completes normally.
REQ-033 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ack held 0 -> bus_err pulses exactly 8 cycles after entering I_LO, then IDLE and ram_busy=0; without the macro, mem_req stays high indefinitely.
REQ-034 ram_read=1 with sel=0 in IDLE -> no mem_req, ram_busy stays 0.
